gene_clk_prog: RTL

GENE_CLK_PROG -- requirements
Module: gene_clk_prog

---
 rtl/gene_clk_prog.sv | 101 ++++++++++
 1 files changed

// File: rtl/gene_clk_prog.sv
// Programmable multi-channel clock divider: NB_CH independent divided clocks with
// glitch-free divisor updates at period boundaries and a global phase-realign strobe.
module gene_clk_prog #(
   parameter int NB_CH       = 4,
   parameter int DIV_W       = 26,
   parameter int DEFAULT_DIV = 50_000_000
) (
   input  logic                     clk_50,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic [$clog2(NB_CH)-1:0] wr_ch,
   input  logic [DIV_W-1:0]         wr_div,
   input  logic [NB_CH-1:0]         ch_en,
   input  logic                     sync,
   output logic [NB_CH-1:0]         clk_out,
   output logic [NB_CH-1:0]         tick
);

   localparam int               CH_W    = $clog2(NB_CH);
   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);
   localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

   // Reset asserts asynchronously; release is re-timed through two flops so
   // counting begins on a clean edge.
   logic [1:0] rst_pipe_q;
   logic       run;

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         rst_pipe_q <= 2'b00;
      end else begin
         rst_pipe_q <= {rst_pipe_q[0], 1'b1};
      end
   end

   assign run = rst_pipe_q[1];

   generate
      for (genvar gi = 0; gi < NB_CH; gi++) begin : g_ch
         logic [DIV_W-1:0] act_q, act_d;
         logic [DIV_W-1:0] pend_q, pend_d;
         logic [DIV_W-1:0] cpt_q, cpt_d;
         logic [DIV_W-1:0] eff, eff_d;
         logic             en_q;
         logic             clk_q, clk_d;
         logic             tick_q, tick_d;
         logic             wr_hit, wrap, restart, load;

         always_comb begin
            wr_hit  = wr_en && (wr_ch == CH_W'(gi));
            pend_d  = wr_hit ? wr_div : pend_q;
            eff     = (act_q < MIN_DIV) ? MIN_DIV : act_q;
            wrap    = en_q && ch_en[gi] && (cpt_q == eff - ONE);
            // A fresh enable or a sync both restart the period without a tick.
            restart = ch_en[gi] && (!en_q || sync);
            load    = !ch_en[gi] || restart || wrap;
            act_d   = load ? pend_d : act_q;
            eff_d   = (act_d < MIN_DIV) ? MIN_DIV : act_d;

            if (!ch_en[gi] || restart || wrap) begin
               cpt_d = '0;
            end else begin
               cpt_d = cpt_q + ONE;
            end

            tick_d = wrap && !restart;
            clk_d  = ch_en[gi] && (cpt_d < (eff_d >> 1));
         end

         always_ff @(posedge clk_50 or negedge reset_n) begin
            if (!reset_n) begin
               act_q  <= DEF_DIV;
               pend_q <= DEF_DIV;
               cpt_q  <= '0;
               en_q   <= 1'b0;
               clk_q  <= 1'b0;
               tick_q <= 1'b0;
            end else if (!run) begin
               act_q  <= DEF_DIV;
               pend_q <= DEF_DIV;
               cpt_q  <= '0;
               en_q   <= 1'b0;
               clk_q  <= 1'b0;
               tick_q <= 1'b0;
            end else begin
               act_q  <= act_d;
               pend_q <= pend_d;
               cpt_q  <= cpt_d;
               en_q   <= ch_en[gi];
               clk_q  <= clk_d;
               tick_q <= tick_d;
            end
         end

         assign clk_out[gi] = clk_q;
         assign tick[gi]    = tick_q;
      end
   endgenerate

endmodule
